// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction-fetch unit:
//   npc_sel_e     redirect kind driven by decode (seq / beq / j,jal / jr)
//   INSTR_W       instruction width in bits
//   IFU_RESET_PC  default word address fetched first after reset (byte 0x3000)
// -----------------------------------------------------------------------------
package ifu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BEQ = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_sel_e;

   localparam int INSTR_W = 32;

   localparam logic [29:0] IFU_RESET_PC = 30'h0000_0C00;

endpackage : ifu_pkg

// File: rtl/ifu_fq.sv
// -----------------------------------------------------------------------------
// ifu_fq
// Synchronous FIFO with a single-cycle flush, used as the prefetch queue.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset (empties the queue)
//   flush_i  in   discard all entries at the next edge; wins over push/pop
//   push_i   in   write wdata_i at the tail (caller guarantees not full)
//   wdata_i  in   W-bit entry
//   pop_i    in   drop the head entry (ignored when empty)
//   rdata_o  out  head entry (undefined content when count_o == 0)
//   valid_o  out  queue holds at least one entry
//   count_o  out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module ifu_fq #(
   parameter  int W     = 62,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries data only; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule : ifu_fq

// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
// Decoupled instruction-fetch unit. Keeps the PC, issues one word-address read
// per cycle to a 1-cycle-latency instruction memory while queue credit is
// available, buffers responses in a flushable prefetch queue (ifu_fq) and
// hands them to decode over valid/ready. Decode-resolved redirects reload the
// PC, flush the queue and squash the in-flight read.
//
// Build option: define IFU_JR_EN to make npc_sel=11 redirect to
// redir_reg[AW+1:2]; otherwise npc_sel=11 behaves as sequential.
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   im_req     out  instruction-memory read strobe
//   im_addr    out  word address of the current request (= PC)
//   im_rdata   in   instruction for the request of the previous cycle
//   ins        out  head instruction (0 when ins_valid=0)
//   ins_pc     out  word address of ins (0 when ins_valid=0)
//   jal_ins    out  ins_pc+1 link address (0 when ins_valid=0)
//   ins_valid  out  head entry present
//   ins_ready  in   decode accepts head
//   npc_sel    in   redirect kind: 00 seq, 01 beq, 10 j/jal, 11 jr
//   redir_pc   in   word address of the control instruction
//   zero       in   beq condition
//   imm        in   instr[25:0]
//   redir_reg  in   rs value for jr (byte address)
// -----------------------------------------------------------------------------
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int             AW         = 30,
   parameter int             FIFO_DEPTH = 4,
   parameter logic [AW-1:0]  RESET_PC   = AW'(IFU_RESET_PC)
) (
   input  logic          clk,
   input  logic          reset,
   output logic          im_req,
   output logic [AW-1:0] im_addr,
   input  logic [31:0]   im_rdata,
   output logic [31:0]   ins,
   output logic [AW-1:0] ins_pc,
   output logic [AW-1:0] jal_ins,
   output logic          ins_valid,
   input  logic          ins_ready,
   input  logic [1:0]    npc_sel,
   input  logic [AW-1:0] redir_pc,
   input  logic          zero,
   input  logic [25:0]   imm,
   input  logic [31:0]   redir_reg
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = AW + INSTR_W;

   // Bits of a j target taken from the instruction; the rest come from PC+1.
   localparam logic [AW-1:0] J_MASK = AW'(32'h03FF_FFFF);

   logic [AW-1:0] pc_q, pc_d;
   logic          infl_q, infl_d;
   logic [AW-1:0] infl_pc_q, infl_pc_d;

   logic [AW-1:0] link_pc;
   logic [AW-1:0] beq_tgt;
   logic [AW-1:0] j_tgt;
   logic          taken;
   logic [AW-1:0] target;

   logic          q_valid;
   logic [FW-1:0] q_rdata;
   logic [CW-1:0] q_count;
   logic          pop;
   logic          push;
   logic [CW:0]   occupancy;
   logic          credit_ok;

   logic          unused_redir;

   // ---------------------------------------------------------------------
   // Redirect target selection
   // ---------------------------------------------------------------------
   assign link_pc = redir_pc + 1'b1;
   assign beq_tgt = link_pc + {{(AW-16){imm[15]}}, imm[15:0]};
   assign j_tgt   = (link_pc & ~J_MASK) | AW'(imm);

   always_comb begin
      taken  = 1'b0;
      target = link_pc;
      case (npc_sel)
         NPC_BEQ: begin
            if (zero) begin
               taken  = 1'b1;
               target = beq_tgt;
            end
         end
         NPC_J: begin
            taken  = 1'b1;
            target = j_tgt;
         end
`ifdef IFU_JR_EN
         NPC_JR: begin
            taken  = 1'b1;
            target = redir_reg[AW+1:2];
         end
`endif
         default: ;
      endcase
   end

   // Only part of redir_reg (or none of it) feeds the datapath.
   assign unused_redir = ^redir_reg;

   // ---------------------------------------------------------------------
   // Credit and request
   // ---------------------------------------------------------------------
   assign pop = q_valid & ins_ready;

   // Entries that will be owned after this edge: stored + in flight - leaving.
   // pop implies count >= 1, so the subtraction cannot wrap.
   assign occupancy = {1'b0, q_count} + (CW+1)'(infl_q) - (CW+1)'(pop);
   assign credit_ok = occupancy < (CW+1)'(FIFO_DEPTH);

   // reset is included so the strobe drops immediately, without an edge.
   assign im_req  = ~reset & ~taken & credit_ok;
   assign im_addr = pc_q;

   // The response of the previous cycle's read is dropped on a redirect.
   assign push = infl_q & ~taken;

   always_comb begin
      pc_d      = pc_q;
      infl_d    = 1'b0;
      infl_pc_d = infl_pc_q;
      if (taken) begin
         pc_d = target;
      end else if (im_req) begin
         pc_d      = pc_q + 1'b1;
         infl_d    = 1'b1;
         infl_pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         infl_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
      end
   end

   // The captured PC is qualified by infl_q, so it needs no reset.
   always_ff @(posedge clk) begin
      infl_pc_q <= infl_pc_d;
   end

   // ---------------------------------------------------------------------
   // Prefetch queue and decode-side outputs
   // ---------------------------------------------------------------------
   ifu_fq #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fq (
      .clk     (clk),
      .reset   (reset),
      .flush_i (taken),
      .push_i  (push),
      .wdata_i ({infl_pc_q, im_rdata}),
      .pop_i   (pop),
      .rdata_o (q_rdata),
      .valid_o (q_valid),
      .count_o (q_count)
   );

   assign ins_valid = q_valid;
   assign ins       = q_valid ? q_rdata[INSTR_W-1:0] : '0;
   assign ins_pc    = q_valid ? q_rdata[FW-1:INSTR_W] : '0;
   assign jal_ins   = q_valid ? (q_rdata[FW-1:INSTR_W] + 1'b1) : '0;

endmodule : ifu_prefetch
